// File: rtl/uop_decode_queue.sv
// uop_decode_queue: multi-lane micro-op queue with per-lane class decode.
// Up to LANES micro-ops enter per cycle in lane order. Each one is decoded
// into 16 class flags on the way in, and the flags are stored with it. The
// LANES oldest entries are presented in order at the output.
// Optional feature: define UOQ_BYPASS_EN so that an empty queue passes its
// inputs straight to the outputs in the same cycle.

`ifndef UOQ_OPCODES_DEFINED
`define UOQ_OPCODES_DEFINED
`define UO_NOP   8'h00
`define UO_ADDB  8'h01
`define UO_ADDW  8'h02
`define UO_SUBB  8'h03
`define UO_ADDWR 8'h07
`define UO_CMPB  8'h08
`define UO_LDB   8'h10
`define UO_LDW   8'h11
`define UO_LDT   8'h12
`define UO_STB   8'h18
`define UO_STW   8'h19
`define UO_STJ   8'h1B
`define UO_FADD  8'h20
`define UO_SEI   8'h30
`define UO_JMP   8'h31
`define UO_JSR   8'h32
`define UO_BEQ   8'h38
`endif

// UopClassDecode: opcode to class flags for a single lane (pure combinational).
module UopClassDecode (
  input  logic [7:0]  opcode_i,
  output logic [15:0] flags_o
);

  // Classify the opcode. Any opcode with no class, other than NOP, is illegal.
  always_comb begin
    flags_o = '0;
    case (opcode_i)
      `UO_NOP: begin
        flags_o[15] = 1'b0;
      end
      `UO_ADDB, `UO_ADDW, `UO_SUBB: begin
        flags_o[0]  = 1'b1;
        flags_o[11] = 1'b1;
      end
      `UO_ADDWR: begin
        flags_o[0]  = 1'b1;
        flags_o[11] = 1'b1;
        flags_o[12] = 1'b1;
      end
      `UO_CMPB: begin
        flags_o[0]  = 1'b1;
        flags_o[7]  = 1'b1;
        flags_o[11] = 1'b1;
      end
      `UO_LDB, `UO_LDW, `UO_LDT: begin
        flags_o[1]  = 1'b1;
        flags_o[3]  = 1'b1;
        flags_o[11] = 1'b1;
        flags_o[6:5] = (opcode_i == `UO_LDB) ? 2'd0 :
                       (opcode_i == `UO_LDW) ? 2'd1 : 2'd2;
      end
      `UO_STB, `UO_STW, `UO_STJ: begin
        flags_o[1]  = 1'b1;
        flags_o[4]  = 1'b1;
        flags_o[6:5] = (opcode_i == `UO_STB) ? 2'd0 :
                       (opcode_i == `UO_STW) ? 2'd1 : 2'd2;
      end
      `UO_FADD: begin
        flags_o[2]  = 1'b1;
        flags_o[11] = 1'b1;
      end
      `UO_SEI: begin
        flags_o[8]  = 1'b1;
      end
      `UO_JMP: begin
        flags_o[9]  = 1'b1;
      end
      `UO_JSR: begin
        flags_o[9]  = 1'b1;
        flags_o[11] = 1'b1;
      end
      `UO_BEQ: begin
        flags_o[10] = 1'b1;
      end
      default: begin
        flags_o[15] = 1'b1;
      end
    endcase
    flags_o[13] = 1'b1;
    flags_o[14] = 1'b0;
  end

endmodule

module uop_decode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [LANES-1:0]              in_valid_i,
  input  logic [24*LANES-1:0]           in_uop_i,
  input  logic [LANES-1:0]              in_pt_i,
  output logic                          in_ready_o,
  output logic [LANES-1:0]              out_valid_o,
  output logic [24*LANES-1:0]           out_uop_o,
  output logic [16*LANES-1:0]           out_flags_o,
  output logic [LANES-1:0]              out_pt_o,
  input  logic [$clog2(LANES+1)-1:0]    out_take_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(LANES + 1);

  logic [23:0]   uopMem_q   [DEPTH];
  logic [15:0]   flagsMem_q [DEPTH];
  logic          ptMem_q    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [15:0]   inFlags [LANES];
  logic [TW-1:0] enqCnt;
  logic [TW-1:0] numValid;
  logic [TW-1:0] deqCnt;
  logic [TW-1:0] skipCnt;
  logic [TW-1:0] storeCnt;
  logic [TW-1:0] deqQueue;
  logic          stopScan;
  logic          bypassActive;
  logic          inReady;
  logic          enqFire;
  logic [LANES-1:0] wrEn;
  logic [PW-1:0] wrAddr [LANES];
  logic [PW-1:0] rdAddr [LANES];

  // One decoder per input lane. Flags are fixed at enqueue time.
  for (genvar g = 0; g < LANES; g++) begin : gDecode
    UopClassDecode uDecode (
      .opcode_i (in_uop_i[24*g+16 +: 8]),
      .flags_o  (inFlags[g])
    );
  end

  // Only the unbroken run of valid lanes starting at lane 0 is enqueued.
  always_comb begin
    enqCnt   = '0;
    stopScan = 1'b0;
    for (int n = 0; n < LANES; n++) begin
      if (!stopScan && in_valid_i[n]) begin
        enqCnt = enqCnt + TW'(1);
      end else begin
        stopScan = 1'b1;
      end
    end
  end

`ifdef UOQ_BYPASS_EN
  assign bypassActive = (count_q == '0) && !flush_i;
`else
  assign bypassActive = 1'b0;
`endif

  // Handshake, dequeue amount, and which input lanes get written where.
  // Under bypass, the lanes taken this cycle skip storage entirely.
  always_comb begin
    inReady = (count_q <= CW'(DEPTH - LANES));
    if (bypassActive) begin
      numValid = enqCnt;
    end else if (count_q >= CW'(LANES)) begin
      numValid = TW'(LANES);
    end else begin
      numValid = TW'(count_q);
    end
    deqCnt   = (out_take_i > numValid) ? numValid : out_take_i;
    enqFire  = inReady && (enqCnt != '0) && !flush_i;
    skipCnt  = bypassActive ? deqCnt : '0;
    deqQueue = (bypassActive || flush_i) ? '0 : deqCnt;
    storeCnt = enqFire ? (enqCnt - skipCnt) : '0;
    for (int k = 0; k < LANES; k++) begin
      wrEn[k]   = enqFire && !rst_i && (TW'(k) >= skipCnt) && (TW'(k) < enqCnt);
      wrAddr[k] = tail_q + PW'(k) - PW'(skipCnt);
    end
  end

  // Pointer and occupancy update. A flush discards same-cycle traffic.
  always_comb begin
    head_d  = head_q + PW'(deqQueue);
    tail_d  = tail_q + PW'(storeCnt);
    count_d = count_q + CW'(storeCnt) - CW'(deqQueue);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer registers. Reset overrides flush and all traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is write-only state with no reset; the pointers say what is live.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (wrEn[k]) begin
        uopMem_q[wrAddr[k]]   <= in_uop_i[24*k +: 24];
        flagsMem_q[wrAddr[k]] <= inFlags[k];
        ptMem_q[wrAddr[k]]    <= in_pt_i[k];
      end
    end
  end

  // Present the oldest entries, or the live inputs when bypassing an empty queue.
  always_comb begin
    out_valid_o = '0;
    out_uop_o   = '0;
    out_flags_o = '0;
    out_pt_o    = '0;
    for (int n = 0; n < LANES; n++) begin
      rdAddr[n] = head_q + PW'(n);
      if (bypassActive) begin
        out_valid_o[n]          = (TW'(n) < enqCnt);
        out_uop_o[24*n +: 24]   = in_uop_i[24*n +: 24];
        out_flags_o[16*n +: 16] = inFlags[n];
        out_pt_o[n]             = in_pt_i[n];
      end else begin
        out_valid_o[n]          = (CW'(n) < count_q);
        out_uop_o[24*n +: 24]   = uopMem_q[rdAddr[n]];
        out_flags_o[16*n +: 16] = flagsMem_q[rdAddr[n]];
        out_pt_o[n]             = ptMem_q[rdAddr[n]];
      end
    end
  end

  assign in_ready_o = inReady;
  assign count_o    = count_q;

endmodule

// File: tb/tb_uop_decode_queue.sv
// tb_uop_decode_queue: table-driven decode vectors, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
// Honours UOQ_BYPASS_EN when the design is built with it.

module tb_uop_decode_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
`ifdef UOQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [7:0] OP_NOP = 8'h00, OP_ADDB = 8'h01, OP_ADDW = 8'h02,
    OP_SUBB = 8'h03, OP_ADDWR = 8'h07, OP_CMPB = 8'h08, OP_LDB = 8'h10,
    OP_LDW = 8'h11, OP_LDT = 8'h12, OP_STB = 8'h18, OP_STW = 8'h19,
    OP_STJ = 8'h1B, OP_FADD = 8'h20, OP_SEI = 8'h30, OP_JMP = 8'h31,
    OP_JSR = 8'h32, OP_BEQ = 8'h38;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] flags;
    string       name;
  } decVec_t;

  typedef struct {
    logic [23:0] uop;
    logic        pt;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_i, flush_i;
  logic [1:0]  in_valid_i, in_pt_i, out_valid_o, out_pt_o, out_take_i;
  logic [47:0] in_uop_i, out_uop_o;
  logic [31:0] out_flags_o;
  logic        in_ready_o;
  logic [3:0]  count_o;

  decVec_t decTab[17];
  entry_t  model[$];
  int      checks = 0;
  int      passes = 0;

  always #5 clk = ~clk;

  uop_decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_uop_i    (in_uop_i),
    .in_pt_i     (in_pt_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_uop_o   (out_uop_o),
    .out_flags_o (out_flags_o),
    .out_pt_o    (out_pt_o),
    .out_take_i  (out_take_i),
    .count_o     (count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] refFlags(input logic [7:0] op);
    foreach (decTab[i]) if (decTab[i].op == op) return decTab[i].flags;
    return 16'hA000;
  endfunction

  function automatic int lead(input logic [1:0] v);
    return v[0] ? (v[1] ? 2 : 1) : 0;
  endfunction

  // Compare every visible output against what the model expects right now.
  task automatic checkOutput(input logic [1:0] v, input logic [47:0] u,
                             input logic [1:0] pt, input logic fl);
    bit byp;
    int nv;
    logic [23:0] eu;
    logic        ep;
    byp = BYPASS && model.size() == 0 && !fl;
    check("count", count_o, model.size());
    check("in_ready", in_ready_o, (DEPTH - model.size()) >= LANES);
    nv = byp ? lead(v) : (model.size() < LANES ? model.size() : LANES);
    for (int n = 0; n < LANES; n++) begin
      check("out_valid", out_valid_o[n], n < nv);
      if (n < nv) begin
        eu = byp ? u[24*n +: 24] : model[n].uop;
        ep = byp ? pt[n] : model[n].pt;
        check("out_uop", out_uop_o[24*n +: 24], eu);
        check("out_flags", out_flags_o[16*n +: 16], refFlags(eu[23:16]));
        check("out_pt", out_pt_o[n], ep);
      end
    end
  endtask

  // Advance the reference model by one clock edge.
  task automatic modelStep(input logic [1:0] v, input logic [47:0] u, input logic [1:0] pt,
                           input logic [1:0] take, input logic fl, input logic rs);
    int enq, nv, deq;
    bit ready, byp;
    entry_t e;
    if (rs || fl) begin
      model.delete();
    end else begin
      enq   = lead(v);
      byp   = BYPASS && model.size() == 0;
      ready = (DEPTH - model.size()) >= LANES;
      if (byp) begin
        deq = (take > enq) ? enq : int'(take);
        for (int k = deq; k < enq; k++) begin
          e.uop = u[24*k +: 24]; e.pt = pt[k]; model.push_back(e);
        end
      end else begin
        nv  = (model.size() < LANES) ? model.size() : LANES;
        deq = (take > nv) ? nv : int'(take);
        for (int k = 0; k < deq; k++) void'(model.pop_front());
        if (ready) begin
          for (int k = 0; k < enq; k++) begin
            e.uop = u[24*k +: 24]; e.pt = pt[k]; model.push_back(e);
          end
        end
      end
    end
  endtask

  // One cycle: drive inputs, check outputs, clock, update the model.
  task automatic applyStimulus(input logic [1:0] v, input logic [23:0] u0, input logic [23:0] u1,
                               input logic [1:0] pt, input logic [1:0] take,
                               input logic fl, input logic rs);
    in_valid_i = v; in_uop_i = {u1, u0}; in_pt_i = pt;
    out_take_i = take; flush_i = fl; rst_i = rs;
    #1;
    checkOutput(v, {u1, u0}, pt, fl);
    modelStep(v, {u1, u0}, pt, take, fl, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic doFlush();
    applyStimulus(2'b00, 24'h0, 24'h0, 2'b00, 2'd0, 1'b1, 1'b0);
  endtask

  function automatic logic [23:0] randUop();
    logic [31:0] r;
    logic [7:0]  op;
    r  = $urandom();
    op = (r[31:30] == 2'b00) ? r[29:22] : decTab[$urandom_range(16, 0)].op;
    return {op, r[15:0]};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [23:0] ua, ub;
    int steady;

    decTab[0]  = '{OP_NOP,   16'h2000, "nop"};
    decTab[1]  = '{OP_ADDB,  16'h2801, "addb"};
    decTab[2]  = '{OP_ADDW,  16'h2801, "addw"};
    decTab[3]  = '{OP_SUBB,  16'h2801, "subb"};
    decTab[4]  = '{OP_ADDWR, 16'h3801, "addwr"};
    decTab[5]  = '{OP_CMPB,  16'h2881, "cmpb"};
    decTab[6]  = '{OP_LDB,   16'h280A, "ldb"};
    decTab[7]  = '{OP_LDW,   16'h282A, "ldw"};
    decTab[8]  = '{OP_LDT,   16'h284A, "ldt"};
    decTab[9]  = '{OP_STB,   16'h2012, "stb"};
    decTab[10] = '{OP_STW,   16'h2032, "stw"};
    decTab[11] = '{OP_STJ,   16'h2052, "stj"};
    decTab[12] = '{OP_FADD,  16'h2804, "fadd"};
    decTab[13] = '{OP_SEI,   16'h2100, "sei"};
    decTab[14] = '{OP_JMP,   16'h2200, "jmp"};
    decTab[15] = '{OP_JSR,   16'h2A00, "jsr"};
    decTab[16] = '{OP_BEQ,   16'h2400, "beq"};

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = '0; in_uop_i = '0;
    in_pt_i = '0; out_take_i = '0;
    @(posedge clk); @(posedge clk); #1;
    model.delete();
    check("reset count", count_o, 0);
    check("reset out_valid", out_valid_o, 0);
    check("reset in_ready", in_ready_o, 1);

    // LDB + ADDB pair, nothing taken.
    applyStimulus(2'b11, {OP_LDB, 16'h0123}, {OP_ADDB, 16'h0456}, 2'b01, 2'd0, 1'b0, 1'b0);
    check("pair count", count_o, 2);
    check("pair lane0 flags", out_flags_o[15:0], 16'h280A);
    check("pair lane1 flags", out_flags_o[31:16], 16'h2801);

    // Decode table, one opcode at a time, plus an unclassified opcode.
    foreach (decTab[i]) begin
      doFlush();
      applyStimulus(2'b01, {decTab[i].op, 16'h5A3C}, 24'h0, 2'b00, 2'd0, 1'b0, 1'b0);
      check({"flags ", decTab[i].name}, out_flags_o[15:0], decTab[i].flags);
    end
    doFlush();
    applyStimulus(2'b01, {8'hEE, 16'h1111}, 24'h0, 2'b00, 2'd0, 1'b0, 1'b0);
    check("flags illegal", out_flags_o[15:0], 16'hA000);

    // Valid prefix: a gap at lane 0 enqueues nothing.
    doFlush();
    applyStimulus(2'b10, {OP_ADDB, 16'h0001}, {OP_ADDB, 16'h0002}, 2'b00, 2'd0, 1'b0, 1'b0);
    check("prefix 10 count", count_o, 0);
    applyStimulus(2'b01, {OP_ADDB, 16'h0003}, {OP_ADDB, 16'h0004}, 2'b00, 2'd0, 1'b0, 1'b0);
    check("prefix 01 count", count_o, 1);

    // Fill to full; the ninth enqueue is dropped.
    doFlush();
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b11, {OP_SUBB, 16'(2*i)}, {OP_SUBB, 16'(2*i+1)}, 2'b10, 2'd0, 1'b0, 1'b0);
    check("full count", count_o, 8);
    check("full in_ready", in_ready_o, 0);
    applyStimulus(2'b11, {OP_JMP, 16'h0999}, {OP_JMP, 16'h0998}, 2'b00, 2'd0, 1'b0, 1'b0);
    check("dropped count", count_o, 8);
    doFlush();
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b11, {OP_ADDB, 16'(i)}, {OP_ADDB, 16'(i)}, 2'b00, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'b01, {OP_ADDB, 16'h0007}, 24'h0, 2'b00, 2'd0, 1'b0, 1'b0);
    check("seven count", count_o, 7);
    check("seven in_ready", in_ready_o, 0);

    // Flush at count 5 discards a same-cycle enqueue.
    doFlush();
    applyStimulus(2'b11, {OP_LDW, 16'h0010}, {OP_LDW, 16'h0011}, 2'b00, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'b11, {OP_LDW, 16'h0012}, {OP_LDW, 16'h0013}, 2'b00, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'b01, {OP_LDW, 16'h0014}, 24'h0, 2'b00, 2'd0, 1'b0, 1'b0);
    check("pre-flush count", count_o, 5);
    applyStimulus(2'b11, {OP_BEQ, 16'h0015}, {OP_BEQ, 16'h0016}, 2'b00, 2'd1, 1'b1, 1'b0);
    check("flush count", count_o, 0);
    check("flush out_valid", out_valid_o, 0);

`ifdef UOQ_BYPASS_EN
    // Same-cycle visibility on an empty queue.
    in_valid_i = 2'b01; in_uop_i = {24'h0, OP_STJ, 16'h0ABC}; flush_i = 1'b0;
    out_take_i = 2'd0; #1;
    check("bypass same-cycle valid", out_valid_o[0], 1);
    check("bypass same-cycle flags", out_flags_o[15:0], 16'h2052);
    applyStimulus(2'b01, {OP_STJ, 16'h0ABC}, 24'h0, 2'b00, 2'd0, 1'b0, 1'b0);
    doFlush();
`endif

    // Steady stream: two in, two out for 20 cycles; order checked by the model.
    applyStimulus(2'b11, {OP_ADDB, 16'h0100}, {OP_ADDB, 16'h0101}, 2'b01, 2'd2, 1'b0, 1'b0);
    steady = model.size();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(2'b11, {OP_ADDB, 16'(16'h0100 + 2*i)}, {OP_LDB, 16'(16'h0101 + 2*i)},
                    2'(i), 2'd2, 1'b0, 1'b0);
      check("steady count", count_o, steady);
    end

    // Reset wins over flush, enqueue and dequeue.
    applyStimulus(2'b11, {OP_FADD, 16'h0200}, {OP_FADD, 16'h0201}, 2'b00, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'b11, {OP_FADD, 16'h0202}, {OP_FADD, 16'h0203}, 2'b11, 2'd1, 1'b1, 1'b1);
    check("mid reset count", count_o, 0);
    check("mid reset out_valid", out_valid_o, 0);
    check("mid reset in_ready", in_ready_o, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ua = randUop();
      ub = randUop();
      applyStimulus(2'($urandom()), ua, ub, 2'($urandom()), 2'($urandom()),
                    ($urandom_range(22, 0) == 0), ($urandom_range(96, 0) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uop_decode_queue.md
UOP_DECODE_QUEUE -- requirements
Module: uop_decode_queue

Interface
REQ-001 Parameter LANES, default 2, micro-ops accepted and presented per cycle (1..4).
REQ-002 Parameter DEPTH, default 8, queue entries; power of two, DEPTH >= 2*LANES.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 flush_i  input  1  discard all queued entries (branch mispredict).
REQ-006 in_valid_i  input  LANES  per-lane micro-op valid.
REQ-007 in_uop_i  input  24*LANES  micro-ops; lane n at [24n+23:24n]; [23:16] opcode, [11:8] dst, [7:4] src1, [3:0] src2.
REQ-008 in_pt_i  input  LANES  per-lane predict-taken.
REQ-009 in_ready_o  output  1  queue will accept a full LANES group this cycle.
REQ-010 out_valid_o  output  LANES  per-lane output valid, contiguous from lane 0.
REQ-011 out_uop_o  output  24*LANES  raw micro-ops, oldest in lane 0.
REQ-012 out_flags_o  output  16*LANES  decoded class flags per lane.
REQ-013 out_pt_o  output  LANES  predict-taken per lane.
REQ-014 out_take_i  input  clog2(LANES+1)  number of leading output lanes consumed this cycle.
REQ-015 count_o  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-016 Flag bits: 0 alu, 1 mem, 2 fcu, 3 load, 4 store, 6:5 memsz (0 byte, 1 wyde, 2 tribyte), 7 cmp, 8 sei, 9 jmp, 10 branch, 11 rfw, 12 wrap, 13 need_sr (constant 1), 14 bt (constant 0), 15 illegal (opcode in no class and not UO_NOP).
REQ-017 Class membership uses the `UO_* opcode defines; one combinational decoder instance per input lane; flags are computed at enqueue and stored with the entry.
REQ-018 Enqueue count = number of leading 1s in in_valid_i from lane 0; lanes after the first 0 are ignored.
REQ-019 in_ready_o = (DEPTH - count_o) >= LANES, computed from registered count only (no dequeue look-ahead).
REQ-020 Enqueue occurs when in_ready_o is high and enqueue count > 0; entries are written in lane order at tail, tail advances modulo DEPTH.
REQ-021 Enqueue with in_ready_o low is dropped; the source must hold its inputs.
REQ-022 Output lane n presents entry head+n (mod DEPTH) with out_valid_o[n] = (n < count_o).
REQ-023 Dequeue count = min(out_take_i, number of valid output lanes); head advances modulo DEPTH.
REQ-024 Simultaneous enqueue and dequeue allowed; count_o next = count_o + enq - deq.
REQ-025 Latency enqueue-to-output: 1 cycle (without bypass).
REQ-026 flush_i clears head, tail and count next cycle; same-cycle enqueue and dequeue are discarded.
REQ-027 Entry storage is not reset; only pointers and count are reset.

Reset
REQ-028 rst_i high at a clock edge: head=0, tail=0, count_o=0; out_valid_o=0 and in_ready_o=1 the following cycle.
REQ-029 rst_i has priority over flush_i, enqueue and dequeue, including mid-operation.

Configuration
REQ-030 Macro UOQ_BYPASS_EN: when defined and count_o=0 and flush_i low, input lanes drive outputs combinationally (out_valid_o = enqueue-valid prefix, flags from the input decoders); lanes consumed via out_take_i are not written, the remainder are enqueued; zero-cycle latency.
REQ-031 Without UOQ_BYPASS_EN: outputs come only from queue storage; latency per REQ-025.

Verification
REQ-032 Reset, then in_valid_i=2'b11 with UO_LDB and UO_ADDB, out_take_i=0 -> next cycle count_o=2, lane0 flags load|mem|rfw, memsz=0; lane1 flags alu|rfw.
REQ-033 Fill to DEPTH=8 with no dequeue -> in_ready_o low at count 7 and 8; a ninth enqueue is dropped and count_o stays 8.
REQ-034 Continuous enqueue of 2 and out_take_i=2 for 20 cycles -> count_o constant; pointers wrap; output order matches input order.
REQ-035 in_valid_i=2'b10 -> nothing enqueued; in_valid_i=2'b01 -> one entry enqueued.
REQ-036 count_o=5, flush_i together with enqueue of 2 -> count_o=0 next cycle; out_valid_o=0.
REQ-037 Opcode outside all classes -> flag 15 set; UO_STJ -> store|mem, memsz=2; with UOQ_BYPASS_EN on an empty queue, out_valid_o is high in the same cycle as the input.
